fetch_sequencer: RTL and testbench

- Program-counter sequencer and fetch buffer for the MIPS core's combinational instruction ROM (8-bit word address in, 32-bit instruction out).
- Drives the ROM address and captures each returned word with its PC tag into a 2-entry queue.
- Presents the queue head to decode over a valid/ready handshake.
- Handles start, halt, end-of-program and branch/jump redirects with queue flush.

---
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer and 2-entry fetch buffer sitting
// between a combinational instruction ROM and the decode stage. Each fetched
// word is tagged with its PC and handed to decode over valid/ready.
module fetch_sequencer #(
  parameter int              AW       = 8,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [AW-1:0]   PC_LIMIT = AW'(255)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_rd,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    cnt_q, cnt_d;

  // Slot 0 is always the queue head; slot 1 shifts down on a pop.
  logic [DW-1:0] q_data_q [0:1];
  logic [DW-1:0] q_data_d [0:1];
  logic [AW-1:0] q_pc_q   [0:1];
  logic [AW-1:0] q_pc_d   [0:1];

  logic          pop;
  logic          push;
  logic          q_empty;

  assign q_empty = (cnt_q == 2'd0);

  // A redirect flushes the queue, so any handshake in that cycle is void.
  assign pop  = !q_empty && instr_ready && !redirect_valid;

  // Fetch only while running; a full queue can still accept if it pops.
  assign push = (state_q == ST_RUN) && !redirect_valid && !halt &&
                ((cnt_q < 2'd2) || pop);

  // Next-state, next-pc and queue update; redirect overrides everything.
  always_comb begin
    logic [1:0] cnt_tmp;
    state_d  = state_q;
    pc_d     = pc_q;
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;
    cnt_tmp  = cnt_q;
    cnt_d    = cnt_q;

    if (redirect_valid) begin
      cnt_d   = 2'd0;
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            state_d = ST_DONE;
          end else if (push) begin
            // Fetching the limit (or anything redirected past it) ends the
            // program; pc is left pointing at the last fetched word.
            if (pc_q >= PC_LIMIT) state_d = ST_DONE;
            else                  pc_d    = pc_q + AW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (pop) begin
        q_data_d[0] = q_data_q[1];
        q_pc_d[0]   = q_pc_q[1];
        cnt_tmp     = cnt_q - 2'd1;
      end
      if (push) begin
        q_data_d[cnt_tmp[0]] = rom_rd;
        q_pc_d[cnt_tmp[0]]   = pc_q;
        cnt_tmp              = cnt_tmp + 2'd1;
      end
      cnt_d = cnt_tmp;
    end
  end

  // Control registers: state, program counter and queue occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // Per-slot payload registers (instruction word and its PC tag).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_data_q[gi] <= '0;
          q_pc_q[gi]   <= '0;
        end else begin
          q_data_q[gi] <= q_data_d[gi];
          q_pc_q[gi]   <= q_pc_d[gi];
        end
      end
    end
  endgenerate

  assign rom_addr    = pc_q;
  assign instr_valid = !q_empty;
  assign instr       = q_empty ? '0 : q_data_q[0];
  assign instr_pc    = q_empty ? '0 : q_pc_q[0];
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios for fetch_sequencer. A default
// instance covers fetch, backpressure, redirect, halt and reset; a second
// instance with PC_LIMIT=6 covers end-of-program.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en, halt, redirect_valid, instr_ready;
  logic [7:0]  redirect_pc;
  logic [7:0]  rom_addr, instr_pc;
  logic [31:0] rom_rd, instr;
  logic        instr_valid, busy, done;

  logic        en_l, halt_l, redirect_valid_l, instr_ready_l;
  logic [7:0]  redirect_pc_l;
  logic [7:0]  rom_addr_l, instr_pc_l;
  logic [31:0] rom_rd_l, instr_l;
  logic        instr_valid_l, busy_l, done_l;

  int errors = 0;
  int checks = 0;

  // Bench ROM: three program words, then an address-tagged filler pattern.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'd0:    rom_word = 32'h20010003;
      8'd1:    rom_word = 32'h20020009;
      8'd2:    rom_word = 32'h00221020;
      default: rom_word = {24'hC0FFEE, a};
    endcase
  endfunction

  assign rom_rd   = rom_word(rom_addr);
  assign rom_rd_l = rom_word(rom_addr_l);

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy), .done(done)
  );

  fetch_sequencer #(.PC_LIMIT(8'd6)) dut_lim (
    .clk(clk), .rst_n(rst_n), .en(en_l), .halt(halt_l),
    .redirect_valid(redirect_valid_l), .redirect_pc(redirect_pc_l),
    .rom_addr(rom_addr_l), .rom_rd(rom_rd_l), .instr(instr_l),
    .instr_pc(instr_pc_l), .instr_valid(instr_valid_l),
    .instr_ready(instr_ready_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en = 0; halt = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    en_l = 0; halt_l = 0; redirect_valid_l = 0; redirect_pc_l = 0;
    instr_ready_l = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] pc);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== pc || instr !== rom_word(pc)) begin
      errors++;
      $display("FAIL %s: valid=%b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
               name, instr_valid, instr_pc, instr, pc, rom_word(pc));
    end else
      $display("ok   %s: pc=%h instr=%h", name, instr_pc, instr);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    checks++;
    if ({instr_valid, busy, done} !== 3'b000 || rom_addr !== 8'h00 ||
        instr !== 32'h0 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: v/b/d=%b%b%b addr=%h instr=%h pc=%h, want 000 00 0 0",
               instr_valid, busy, done, rom_addr, instr, instr_pc);
    end else $display("ok   reset_outputs");
    step();
    rst_n = 1;
    step();
    checks++;
    if (busy !== 1'b0 || rom_addr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_fetch: busy=%b addr=%h valid=%b, want 0 00 0",
               busy, rom_addr, instr_valid);
    end else $display("ok   idle_no_fetch");
  endtask

  task automatic test_fetch();
    do_reset();
    en = 1; instr_ready = 1;
    step();
    en = 0;
    checks++;
    if (busy !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: busy=%b valid=%b, want 1 0", busy, instr_valid);
    end else $display("ok   run_entry");
    step(); chk_head("fetch_pc0", 8'd0);
    step(); chk_head("fetch_pc1", 8'd1);
    step(); chk_head("fetch_pc2", 8'd2);
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1; instr_ready = 0;
    step();
    en = 0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (rom_addr !== 8'd2) begin
      errors++;
      $display("FAIL bp_pc_stall: rom_addr=%h, want 02", rom_addr);
    end else $display("ok   bp_pc_stall");
    chk_head("bp_head0", 8'd0);
    instr_ready = 1;
    step(); chk_head("bp_head1", 8'd1);
    step(); chk_head("bp_head2", 8'd2);
  endtask

  // Continues from backpressure: queue holds pc 2,3 and pc is 4.
  task automatic test_redirect();
    checks++;
    if (rom_addr !== 8'd4) begin
      errors++;
      $display("FAIL redir_pre_pc: rom_addr=%h, want 04", rom_addr);
    end else $display("ok   redir_pre_pc");
    instr_ready = 0; redirect_valid = 1; redirect_pc = 8'h10;
    step();
    redirect_valid = 0;
    checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h busy=%b, want 0 10 1",
               instr_valid, rom_addr, busy);
    end else $display("ok   redir_flush");
    step(); chk_head("redir_head", 8'h10);
  endtask

  task automatic test_halt();
    do_reset();
    en = 1; instr_ready = 1;
    for (int i = 0; i < 4; i++) step();
    en = 0;
    checks++;
    if (rom_addr !== 8'd3) begin
      errors++;
      $display("FAIL halt_pre_pc: rom_addr=%h, want 03", rom_addr);
    end else $display("ok   halt_pre_pc");
    instr_ready = 0; halt = 1;
    step();
    halt = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'd3) begin
      errors++;
      $display("FAIL halt_done: done=%b busy=%b addr=%h, want 1 0 03",
               done, busy, rom_addr);
    end else $display("ok   halt_done");
    chk_head("halt_kept", 8'd2);
    en = 1;
    step();
    en = 0;
    checks++;
    if (done !== 1'b1 || rom_addr !== 8'd3) begin
      errors++;
      $display("FAIL done_ignores_en: done=%b addr=%h, want 1 03", done, rom_addr);
    end else $display("ok   done_ignores_en");
    instr_ready = 1;
    step();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h0) begin
      errors++;
      $display("FAIL halt_drained: valid=%b instr=%h pc=%h, want 0 0 0",
               instr_valid, instr, instr_pc);
    end else $display("ok   halt_drained");
  endtask

  task automatic test_halt_redirect();
    do_reset();
    en = 1; instr_ready = 0;
    step(); step();
    en = 0;
    halt = 1; redirect_valid = 1; redirect_pc = 8'h20;
    step();
    halt = 0; redirect_valid = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || rom_addr !== 8'h20 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_redir: busy=%b done=%b addr=%h valid=%b, want 1 0 20 0",
               busy, done, rom_addr, instr_valid);
    end else $display("ok   halt_redir");
    step(); chk_head("halt_redir_head", 8'h20);
  endtask

  task automatic test_reset_mid_run();
    instr_ready = 0;
    checks++;
    if (busy !== 1'b1 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: busy=%b valid=%b, want 1 1", busy, instr_valid);
    end else $display("ok   mid_pre");
    #2 rst_n = 0;
    #1;
    checks++;
    if ({instr_valid, busy, done} !== 3'b000 || rom_addr !== 8'h0 ||
        instr !== 32'h0 || instr_pc !== 8'h0) begin
      errors++;
      $display("FAIL mid_reset: v/b/d=%b%b%b addr=%h instr=%h pc=%h, want 000 00 0 0",
               instr_valid, busy, done, rom_addr, instr, instr_pc);
    end else $display("ok   mid_reset");
    step();
    rst_n = 1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || rom_addr !== 8'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: busy=%b addr=%h valid=%b, want 0 00 0",
               busy, rom_addr, instr_valid);
    end else $display("ok   mid_idle");
    en = 1; instr_ready = 1;
    step();
    en = 0;
    step(); chk_head("mid_resume", 8'd0);
  endtask

  task automatic test_limit();
    logic [7:0] expect_pc;
    logic [7:0] last_pc;
    int         seen;
    do_reset();
    en_l = 1; instr_ready_l = 1;
    step();
    en_l = 0;
    expect_pc = 0; last_pc = 8'hFF; seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (instr_valid_l) begin
        checks++;
        if (instr_pc_l !== expect_pc || instr_l !== rom_word(expect_pc)) begin
          errors++;
          $display("FAIL limit_seq: pc=%h instr=%h, want pc=%h instr=%h",
                   instr_pc_l, instr_l, expect_pc, rom_word(expect_pc));
        end else $display("ok   limit_seq: pc=%h", instr_pc_l);
        last_pc = instr_pc_l;
        expect_pc = expect_pc + 8'd1;
        seen++;
      end
    end
    checks++;
    if (last_pc !== 8'd6 || seen != 7 || done_l !== 1'b1 || busy_l !== 1'b0 ||
        rom_addr_l !== 8'd6 || instr_valid_l !== 1'b0) begin
      errors++;
      $display("FAIL limit_end: last=%h seen=%0d done=%b busy=%b addr=%h valid=%b, want 06 7 1 0 06 0",
               last_pc, seen, done_l, busy_l, rom_addr_l, instr_valid_l);
    end else $display("ok   limit_end");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_reset_mid_run();
    test_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
